// File: rtl/milestone_sram_sequencer.sv
// Milestone sequencer: runs enabled decoder stages in ascending order and
// lends the single SRAM controller port to the running stage, else to the VGA reader.
//
// state  | meaning
// S_IDLE | VGA reader owns SRAM, waiting for Go
// S_RUN  | one stage started, its SRAM signals muxed through, watchdog counting
// S_GAP  | one dead cycle between stages, start low, no writes
// S_DONE | one-cycle Seq_done pulse, then back to S_IDLE
module milestone_sram_sequencer #(
    parameter int          NUM_STAGES     = 3,
    parameter int          ADDR_W         = 18,
    parameter int          DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                         CLOCK_50_I,
    input  logic                         Resetn,
    input  logic                         Go,
    input  logic [NUM_STAGES-1:0]        Stage_enable,
    output logic [NUM_STAGES-1:0]        Stage_start,
    input  logic [NUM_STAGES-1:0]        Stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0] Stage_SRAM_address,
    input  logic [NUM_STAGES*DATA_W-1:0] Stage_SRAM_write_data,
    input  logic [NUM_STAGES-1:0]        Stage_SRAM_we_n,
    input  logic [ADDR_W-1:0]            Idle_SRAM_address,
    output logic [ADDR_W-1:0]            SRAM_address,
    output logic [DATA_W-1:0]            SRAM_write_data,
    output logic                         SRAM_we_n,
    output logic                         VGA_enable,
    output logic                         Busy,
    output logic                         Seq_done,
    output logic                         Timeout_error,
    output logic [3:0]                   Active_stage,
    output logic [31:0]                  Stage_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [31:0]           TIMEOUT_VAL  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0]           TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_STAGES-1:0] ONE_N        = NUM_STAGES'(1);

    state_t                state, state_d;
    logic [NUM_STAGES-1:0] mask, mask_d;
    logic [NUM_STAGES-1:0] start_d;
    logic [3:0]            active_d;
    logic [31:0]           counter, counter_d;
    logic [31:0]           cycles_d;
    logic                  terr_d;
    logic                  done_hit;
    logic [NUM_STAGES-1:0] mask_left;

    function automatic logic [3:0] lowest_idx(input logic [NUM_STAGES-1:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_STAGES-1:0] lowest_onehot(input logic [NUM_STAGES-1:0] m);
        return m & (~m + ONE_N);
    endfunction

    // Stage_start is one-hot on the active stage, so masking done with it
    // ignores done levels from every other stage.
    assign done_hit  = |(Stage_done & Stage_start);
    assign mask_left = mask & ~Stage_start;

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state         <= S_IDLE;
            mask          <= '0;
            Stage_start   <= '0;
            Active_stage  <= '0;
            counter       <= '0;
            Stage_cycles  <= '0;
            Timeout_error <= 1'b0;
            VGA_enable    <= 1'b1;
            Busy          <= 1'b0;
            Seq_done      <= 1'b0;
        end else begin
            state         <= state_d;
            mask          <= mask_d;
            Stage_start   <= start_d;
            Active_stage  <= active_d;
            counter       <= counter_d;
            Stage_cycles  <= cycles_d;
            Timeout_error <= terr_d;
            VGA_enable    <= (state_d == S_IDLE);
            Busy          <= (state_d != S_IDLE);
            Seq_done      <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d   = state;
        mask_d    = mask;
        start_d   = Stage_start;
        active_d  = Active_stage;
        counter_d = counter;
        cycles_d  = Stage_cycles;
        terr_d    = Timeout_error;
        case (state)
            S_IDLE: begin
                if (Go) begin
                    mask_d = Stage_enable;
                    terr_d = 1'b0;
                    if (|Stage_enable) begin
                        active_d  = lowest_idx(Stage_enable);
                        start_d   = lowest_onehot(Stage_enable);
                        counter_d = '0;
                        state_d   = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                counter_d = counter + 32'd1;
                if (done_hit) begin
                    start_d  = '0;
                    cycles_d = counter + 32'd1;
                    mask_d   = mask_left;
                    state_d  = (|mask_left) ? S_GAP : S_DONE;
                end else if (counter == TIMEOUT_LAST) begin
                    // abort skips every remaining stage
                    start_d  = '0;
                    cycles_d = TIMEOUT_VAL;
                    terr_d   = 1'b1;
                    mask_d   = '0;
                    state_d  = S_DONE;
                end
            end
            S_GAP: begin
                active_d  = lowest_idx(mask);
                start_d   = lowest_onehot(mask);
                counter_d = '0;
                state_d   = S_RUN;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        SRAM_address    = Idle_SRAM_address;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        if (state == S_RUN) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (Active_stage == 4'(k)) begin
                    SRAM_address    = Stage_SRAM_address[k*ADDR_W +: ADDR_W];
                    SRAM_write_data = Stage_SRAM_write_data[k*DATA_W +: DATA_W];
                    SRAM_we_n       = Stage_SRAM_we_n[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_milestone_sram_sequencer.sv
// Directed bench for milestone_sram_sequencer: stage ordering, gap, skip mask,
// empty mask, watchdog abort, SRAM ownership mux, Go filtering and async reset.
module tb_milestone_sram_sequencer;

    logic        CLOCK_50_I;
    logic        Resetn;
    logic        Go;
    logic [2:0]  Stage_enable;
    logic [2:0]  Stage_start;
    logic [2:0]  Stage_done;
    logic [53:0] Stage_SRAM_address;
    logic [47:0] Stage_SRAM_write_data;
    logic [2:0]  Stage_SRAM_we_n;
    logic [17:0] Idle_SRAM_address;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        VGA_enable;
    logic        Busy;
    logic        Seq_done;
    logic        Timeout_error;
    logic [3:0]  Active_stage;
    logic [31:0] Stage_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    // stage k asserts done lat[k] cycles after its start rose; lat 0 = never
    int          lat    [3];
    logic [31:0] st_cnt [3];

    milestone_sram_sequencer #(
        .NUM_STAGES(3), .ADDR_W(18), .DATA_W(16), .TIMEOUT_CYCLES(20)
    ) dut (
        .CLOCK_50_I            (CLOCK_50_I),
        .Resetn                (Resetn),
        .Go                    (Go),
        .Stage_enable          (Stage_enable),
        .Stage_start           (Stage_start),
        .Stage_done            (Stage_done),
        .Stage_SRAM_address    (Stage_SRAM_address),
        .Stage_SRAM_write_data (Stage_SRAM_write_data),
        .Stage_SRAM_we_n       (Stage_SRAM_we_n),
        .Idle_SRAM_address     (Idle_SRAM_address),
        .SRAM_address          (SRAM_address),
        .SRAM_write_data       (SRAM_write_data),
        .SRAM_we_n             (SRAM_we_n),
        .VGA_enable            (VGA_enable),
        .Busy                  (Busy),
        .Seq_done              (Seq_done),
        .Timeout_error         (Timeout_error),
        .Active_stage          (Active_stage),
        .Stage_cycles          (Stage_cycles)
    );

    initial CLOCK_50_I = 1'b0;
    always #5 CLOCK_50_I = ~CLOCK_50_I;

    always @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < 3; k++) st_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) st_cnt[k] <= Stage_start[k] ? st_cnt[k] + 32'd1 : 32'd0;
        end
    end

    always_comb begin
        Stage_done = '0;
        for (int k = 0; k < 3; k++) begin
            Stage_done[k] = Stage_start[k] && (lat[k] != 0) && (st_cnt[k] == 32'(lat[k] - 1));
        end
    end

    task automatic tick();
        @(posedge CLOCK_50_I);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_go(input logic [2:0] m);
        Stage_enable = m;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        Stage_enable = ~m;
    endtask

    // waits for stage k to start, then counts the cycles its start stays high
    task automatic run_stage(input int k, input int exp_n, input string tag);
        bit found;
        int n;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Stage_start == 3'(1 << k)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_started"}, 32'(found), 32'd1);
        chk({tag, "_active"}, 32'(Active_stage), 32'(k));
        n = 0;
        while (Stage_start != 3'b000 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_start_len"}, 32'(n), 32'(exp_n));
        chk({tag, "_cycles"}, Stage_cycles, 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        Resetn = 1'b0;
        Go = 1'b0;
        Stage_enable = '0;
        Stage_SRAM_address = {18'h3FFFF, 18'h12345, 18'h00111};
        Stage_SRAM_write_data = {16'hFFFF, 16'hBEEF, 16'h1234};
        Stage_SRAM_we_n = 3'b101;
        Idle_SRAM_address = 18'h0ABCD;
        lat[0] = 10; lat[1] = 11; lat[2] = 12;
        repeat (3) tick();

        chk("rst_start", 32'(Stage_start), 32'd0);
        chk("rst_vga", 32'(VGA_enable), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_seq_done", 32'(Seq_done), 32'd0);
        chk("rst_terr", 32'(Timeout_error), 32'd0);
        chk("rst_active", 32'(Active_stage), 32'd0);
        chk("rst_cycles", Stage_cycles, 32'd0);
        chk("rst_addr", 32'(SRAM_address), 32'h0ABCD);
        chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
        @(negedge CLOCK_50_I);
        Resetn = 1'b1;
        tick();

        // all three stages, latencies 10/11/12
        pulse_go(3'b111);
        chk("t1_go_start", 32'(Stage_start), 32'b001);
        chk("t1_go_vga", 32'(VGA_enable), 32'd0);
        chk("t1_go_busy", 32'(Busy), 32'd1);
        run_stage(0, 10, "t1_s0");
        chk("t1_gap0_start", 32'(Stage_start), 32'd0);
        chk("t1_gap0_vga", 32'(VGA_enable), 32'd0);
        tick();
        chk("t1_after_gap0", 32'(Stage_start), 32'b010);
        run_stage(1, 11, "t1_s1");
        chk("t1_gap1_start", 32'(Stage_start), 32'd0);
        tick();
        chk("t1_after_gap1", 32'(Stage_start), 32'b100);
        run_stage(2, 12, "t1_s2");
        chk("t1_done_pulse", 32'(Seq_done), 32'd1);
        chk("t1_done_vga", 32'(VGA_enable), 32'd0);
        tick();
        chk("t1_idle_pulse", 32'(Seq_done), 32'd0);
        chk("t1_idle_vga", 32'(VGA_enable), 32'd1);
        chk("t1_idle_busy", 32'(Busy), 32'd0);
        tick();

        // stage 1 masked off
        pulse_go(3'b101);
        run_stage(0, 10, "t2_s0");
        tick();
        chk("t2_skip1", 32'(Stage_start), 32'b100);
        run_stage(2, 12, "t2_s2");
        chk("t2_done_pulse", 32'(Seq_done), 32'd1);
        tick();
        chk("t2_active_hold", 32'(Active_stage), 32'd2);
        tick();

        // empty mask
        pulse_go(3'b000);
        chk("t3_done_pulse", 32'(Seq_done), 32'd1);
        chk("t3_start", 32'(Stage_start), 32'd0);
        chk("t3_vga_low", 32'(VGA_enable), 32'd0);
        tick();
        chk("t3_vga_back", 32'(VGA_enable), 32'd1);
        chk("t3_pulse_end", 32'(Seq_done), 32'd0);
        tick();

        // watchdog abort on stage 0, stage 1 must not start
        lat[0] = 0;
        pulse_go(3'b011);
        run_stage(0, 20, "t4_s0");
        chk("t4_terr", 32'(Timeout_error), 32'd1);
        chk("t4_done_pulse", 32'(Seq_done), 32'd1);
        tick();
        chk("t4_no_s1", 32'(Stage_start), 32'd0);
        chk("t4_terr_sticky", 32'(Timeout_error), 32'd1);
        pulse_go(3'b000);
        chk("t4_terr_cleared", 32'(Timeout_error), 32'd0);
        tick();

        // done on the last allowed cycle wins over timeout
        lat[0] = 20;
        pulse_go(3'b001);
        run_stage(0, 20, "t4b_s0");
        chk("t4b_no_terr", 32'(Timeout_error), 32'd0);
        tick();
        tick();

        // SRAM mux, Go during RUN, async reset mid stage 1
        lat[0] = 10;
        pulse_go(3'b011);
        chk("t5_s0_addr", 32'(SRAM_address), 32'h00111);
        chk("t5_s0_we_n", 32'(SRAM_we_n), 32'd1);
        chk("t5_s0_wdata", 32'(SRAM_write_data), 32'h1234);
        run_stage(0, 10, "t5_s0");
        chk("t5_gap_addr", 32'(SRAM_address), 32'h0ABCD);
        chk("t5_gap_we_n", 32'(SRAM_we_n), 32'd1);
        chk("t5_gap_wdata", 32'(SRAM_write_data), 32'd0);
        tick();
        chk("t5_s1_addr", 32'(SRAM_address), 32'h12345);
        chk("t5_s1_we_n", 32'(SRAM_we_n), 32'd0);
        chk("t5_s1_wdata", 32'(SRAM_write_data), 32'hBEEF);
        Stage_enable = 3'b100;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        chk("t5_go_ignored_start", 32'(Stage_start), 32'b010);
        chk("t5_go_ignored_active", 32'(Active_stage), 32'd1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("t5_rst_start", 32'(Stage_start), 32'd0);
        chk("t5_rst_vga", 32'(VGA_enable), 32'd1);
        chk("t5_rst_busy", 32'(Busy), 32'd0);
        chk("t5_rst_cycles", Stage_cycles, 32'd0);
        chk("t5_rst_we_n", 32'(SRAM_we_n), 32'd1);
        #3;
        Resetn = 1'b1;
        repeat (3) tick();
        chk("t5_idle_busy", 32'(Busy), 32'd0);
        chk("t5_idle_start", 32'(Stage_start), 32'd0);
        chk("t5_idle_addr", 32'(SRAM_address), 32'h0ABCD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
